// File: rtl/dl_pkg.sv
// Shared constants and helpers for the multi-channel delay line.
// Pipeline depth, delay floor, counter sizing and delay clamping.
package dl_pkg;

   localparam int PIPE_LAT  = 4;
   localparam int MIN_DELAY = 8;

   // One extra bit so a stamp cannot alias within a single delay window
   function automatic int ctr_width(input int max_delay);
      return $clog2(max_delay + 1) + 1;
   endfunction

   function automatic int clamp_delay(input int d, input int max_delay);
      if (d < MIN_DELAY) return MIN_DELAY;
      if (d > max_delay) return max_delay;
      return d;
   endfunction

endpackage

// File: rtl/delay_line_mc_channel.sv
// One delay channel: input synchroniser, edge detect with holdoff,
// timestamp FIFO, head-of-queue compare and registered trigger.
module dl_channel
   import dl_pkg::*;
#(
   parameter int FIFO_DEPTH = 600,
   parameter int HOLDOFF    = 202,
   parameter int CW         = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pulse,
   input  logic          ovf_clr,
   input  logic [CW-1:0] ctr,
   input  logic [CW-1:0] stamp,
   output logic          trig,
   output logic          fifo_full,
   output logic          ovf,
   output logic          nonempty
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   logic          sync_p0, sync_p1, sync_p2;
   logic          rise_p2;
   logic          vld_p3;
   logic [HW-1:0] hold;
   logic [CW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count;
   logic          accept, full, empty, push, pop, drop;

   always_comb begin
      full   = (count == NW'(FIFO_DEPTH));
      empty  = (count == '0);
      accept = rise_p2 && (hold == '0);
      pop    = !empty && (mem[rd_ptr] == ctr);
      push   = vld_p3 && (!full || pop);
      drop   = vld_p3 && full && !pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
         rise_p2 <= 1'b0;
         vld_p3  <= 1'b0;
         hold    <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         trig    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         // p0/p1: synchroniser, p2: rising-edge detect
         sync_p0 <= pulse;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         rise_p2 <= sync_p1 && !sync_p2;
         // p3: holdoff gate; stamp is written on the following edge
         vld_p3  <= accept;
         if (accept)
            hold <= HW'(HOLDOFF - 1);
         else if (hold != '0)
            hold <= hold - 1'b1;
         if (push)
            wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         trig <= pop;
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= stamp;
   end

   assign fifo_full = full;
   assign nonempty  = !empty;

endmodule

// File: rtl/delay_line_mc.sv
// Multi-channel programmable delay line: shared free-running counter and
// delay register feeding independent timestamp channels.
module delay_line_mc
   import dl_pkg::*;
#(
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 600,
   parameter int MAX_DELAY  = 135000,
   parameter int HOLDOFF    = 202,
   parameter int DEF_DELAY  = 135000,
   localparam int DW        = $clog2(MAX_DELAY + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] in,
   input  logic [DW-1:0]       delay_cycles,
   input  logic                delay_load,
   output logic                delay_busy,
   output logic [CHANNELS-1:0] trig,
   output logic [CHANNELS-1:0] fifo_full,
   output logic [CHANNELS-1:0] ovf,
   input  logic                ovf_clr
);

   localparam int CW = ctr_width(MAX_DELAY);

   logic [1:0]          rst_sync;
   logic                srst_n;
   logic [CW-1:0]       ctr;
   logic [DW-1:0]       delay_q;
   logic [CW-1:0]       stamp;
   logic [CHANNELS-1:0] nonempty;

   // Assert asynchronously, release on the clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign srst_n = rst_sync[1];

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         ctr     <= '0;
         delay_q <= DW'(clamp_delay(DEF_DELAY, MAX_DELAY));
      end else begin
         ctr <= ctr + 1'b1;
         if (delay_load && !delay_busy)
            delay_q <= DW'(clamp_delay(int'(delay_cycles), MAX_DELAY));
      end
   end

   // Stamp is taken one cycle after the holdoff stage, hence the offset
   assign stamp      = ctr + CW'(delay_q) - CW'(PIPE_LAT);
   assign delay_busy = |nonempty;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      dl_channel #(
         .FIFO_DEPTH (FIFO_DEPTH),
         .HOLDOFF    (HOLDOFF),
         .CW         (CW)
      ) u_ch (
         .clk       (clk),
         .rst_n     (srst_n),
         .pulse     (in[g]),
         .ovf_clr   (ovf_clr),
         .ctr       (ctr),
         .stamp     (stamp),
         .trig      (trig[g]),
         .fifo_full (fifo_full[g]),
         .ovf       (ovf[g]),
         .nonempty  (nonempty[g])
      );
   end

endmodule

// File: tb/tb_delay_line_mc.sv
// Scoreboard bench for delay_line_mc: stimulus pushes expected trigger
// cycles per channel, a monitor pops and compares on every trig pulse.
module tb_delay_line_mc;

   localparam int CH = 2;
   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] pulse_in;
   logic [DW-1:0] delay_cycles;
   logic          delay_load;
   logic          delay_busy;
   logic [CH-1:0] trig;
   logic [CH-1:0] fifo_full;
   logic [CH-1:0] ovf;
   logic          ovf_clr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int q0[$];
   int q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   delay_line_mc #(
      .CHANNELS   (2),
      .FIFO_DEPTH (4),
      .MAX_DELAY  (1000),
      .HOLDOFF    (10),
      .DEF_DELAY  (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in           (pulse_in),
      .delay_cycles (delay_cycles),
      .delay_load   (delay_load),
      .delay_busy   (delay_busy),
      .trig         (trig),
      .fifo_full    (fifo_full),
      .ovf          (ovf),
      .ovf_clr      (ovf_clr)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every trig pulse must match the oldest expected cycle
   always @(posedge clk) begin
      #2;
      for (int c = 0; c < CH; c++) begin
         if (trig[c] === 1'b1) begin
            if ((c == 0 ? q0.size() : q1.size()) == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_trig ch%0d: got trig at cycle %0d expected none", c, cyc);
            end else begin
               int e;
               e = (c == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("trig_time_ch%0d", c), cyc, e);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle pulse; capture edge is the posedge after the raise
   task automatic fire(input int c, input int d, input bit expect_trig);
      @(negedge clk);
      pulse_in[c] = 1'b1;
      if (expect_trig) begin
         if (c == 0) q0.push_back(cyc + 1 + d);
         else        q1.push_back(cyc + 1 + d);
      end
      @(negedge clk);
      pulse_in[c] = 1'b0;
   endtask

   task automatic load(input int v);
      @(negedge clk);
      delay_cycles = DW'(v);
      delay_load   = 1'b1;
      @(negedge clk);
      delay_load   = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(negedge clk);
      end
      chk({name, "_drained"}, q0.size() + q1.size(), 0);
      idle(15);
   endtask

   initial begin
      rst_n        = 1'b0;
      pulse_in     = '0;
      delay_cycles = '0;
      delay_load   = 1'b0;
      ovf_clr      = 1'b0;
      idle(3);
      chk("rst_trig", int'(trig), 0);
      chk("rst_full", int'(fifo_full), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_busy", int'(delay_busy), 0);
      rst_n = 1'b1;
      idle(5);

      // Single pulse at default delay
      fire(0, 100, 1'b1);
      idle(6);
      chk("busy_pending", int'(delay_busy), 1);
      drain("t1", 300);

      // Holdoff: 5 apart rejected, 12 apart accepted
      fire(0, 100, 1'b1);
      idle(3);
      fire(0, 0, 1'b0);
      drain("t2a", 300);
      fire(0, 100, 1'b1);
      idle(10);
      fire(0, 100, 1'b1);
      drain("t2b", 300);

      // FIFO fill and overflow on ch1
      for (int k = 0; k < 4; k++) begin
         fire(1, 100, 1'b1);
         if (k < 3) idle(10);
      end
      idle(6);
      chk("full_ch1", int'(fifo_full[1]), 1);
      chk("full_ch0", int'(fifo_full[0]), 0);
      idle(4);
      fire(1, 0, 1'b0);
      idle(6);
      chk("ovf_ch1_set", int'(ovf[1]), 1);
      chk("ovf_ch0_clear", int'(ovf[0]), 0);
      drain("t3", 300);
      chk("full_ch1_after", int'(fifo_full[1]), 0);
      chk("ovf_sticky", int'(ovf[1]), 1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared", int'(ovf), 0);

      // Delay programming, blocked while busy
      load(300);
      fire(0, 300, 1'b1);
      idle(6);
      chk("busy_on_load", int'(delay_busy), 1);
      load(50);
      drain("t4a", 600);
      fire(0, 300, 1'b1);
      drain("t4b", 600);

      // Clamping at both ends
      load(3);
      fire(0, 8, 1'b1);
      drain("t5a", 100);
      load(1023);
      fire(0, 1000, 1'b1);
      drain("t5b", 1200);

      // Pulses spread over more than a full counter period
      for (int k = 0; k < 4; k++) begin
         fire(0, 1000, 1'b1);
         idle(698);
      end
      drain("t6", 2000);

      // Reset with pending stamps discards them
      for (int k = 0; k < 3; k++) begin
         fire(0, 1000, 1'b1);
         idle(10);
      end
      chk("busy_before_rst", int'(delay_busy), 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst2_trig", int'(trig), 0);
      chk("rst2_full", int'(fifo_full), 0);
      chk("rst2_ovf", int'(ovf), 0);
      chk("rst2_busy", int'(delay_busy), 0);
      q0.delete();
      q1.delete();
      idle(3);
      rst_n = 1'b1;
      idle(1100);
      fire(0, 100, 1'b1);
      drain("t6_post_rst", 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
